// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side packer.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    // Widest lane count the keep helper can describe.
    localparam int unsigned MAX_LANES = 32;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } pack_state_t;

    // Keep vector for a partial word: the lowest 'count' lanes are valid.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned count);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < count) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains a FIFO read port one lane at a time and packs PACK_RATIO lanes,
// LSB-first, into one wide word presented on a valid/ready handshake.
// A flush pulse emits the current partial word with a keep mask and last flag.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned PACK_RATIO = 4,
    localparam int unsigned OUT_WIDTH  = DATA_WIDTH * PACK_RATIO,
    localparam int unsigned CNT_W      = $clog2(PACK_RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [PACK_RATIO-1:0] out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CNT_W1 = CNT_W + 1;

    pack_state_t          state;
    logic [CNT_W-1:0]     count;
    logic                 rd_pending;
    logic                 flush_pend;
    logic [OUT_WIDTH-1:0] lanes;

    logic [OUT_WIDTH-1:0] lanes_cap;
    logic [CNT_W1-1:0]    in_use;
    logic                 word_full;

    // Lanes already captured plus the one whose data arrives this cycle.
    assign in_use = {1'b0, count} + CNT_W1'(rd_pending);

    // Read request is combinational so a non-empty FIFO is drained back-to-back.
    assign fifo_rd_en = (state == FILL) && !reset && !fifo_empty && !flush_pend
                        && (in_use < CNT_W1'(PACK_RATIO));

    // This cycle's FIFO data written into the lane selected by count.
    always_comb begin
        lanes_cap = lanes;
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (count == CNT_W'(i)) begin
                lanes_cap[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
            end
        end
    end

    // The capture in progress fills the final lane.
    assign word_full = rd_pending && (count == CNT_W'(PACK_RATIO - 1));

    // Pack FSM: lane capture, word completion, flush and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            count      <= '0;
            rd_pending <= 1'b0;
            flush_pend <= 1'b0;
            lanes      <= '0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    rd_pending <= fifo_rd_en;
                    if (rd_pending) begin
                        // In-flight data is always captured before a flush is honoured.
                        lanes <= lanes_cap;
                        count <= count + CNT_W'(1);
                        if (word_full) begin
                            state     <= OUT;
                            out_data  <= lanes_cap;
                            out_keep  <= '1;
                            out_last  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if (flush_pend) begin
                        // Empty words are never emitted; the flush just retires.
                        flush_pend <= 1'b0;
                        if (count != '0) begin
                            state     <= OUT;
                            out_data  <= lanes;
                            out_keep  <= PACK_RATIO'(keep_mask(32'(count)));
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    rd_pending <= 1'b0;
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        count     <= '0;
                        lanes     <= '0;
                    end
                end
            endcase
            // A new flush request is never lost to a same-cycle retirement.
            if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned PR = 4;
    localparam int unsigned OW = DW * PR;
    localparam int unsigned FIFO_DEPTH = 1 << DEFAULT_ADDR_WIDTH;

    logic          clk;
    logic          reset;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          flush;
    logic [OW-1:0] out_data;
    logic [PR-1:0] out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [PR-1:0] k;
        logic          l;
    } word_t;

    typedef struct {
        int            n;
        logic [31:0]   bytes;
        bit            fl;
        logic          exp_valid;
        logic [31:0]   exp_data;
        logic [3:0]    exp_keep;
        logic          exp_last;
    } vec_t;

    int          checks;
    int          errors;
    logic [7:0]  fq[$];
    logic [7:0]  acc[$];
    word_t       expq[$];
    bit          model_on;
    bit          stall;
    bit          hold_pend;
    word_t       held;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = stall || (fq.size() == 0);
    endtask

    task automatic set_stall(input bit s);
        stall = s;
        fifo_empty = stall || (fq.size() == 0);
    endtask

    task automatic do_reset();
        model_on  = 1'b0;
        hold_pend = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        step();
        fq.delete();
        acc.delete();
        expq.delete();
        set_stall(1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // Reference word from the bytes read since the previous word.
    function automatic word_t pack_word(input bit last);
        word_t w;
        w.d = '0;
        for (int i = 0; i < acc.size(); i++) begin
            w.d[i*8 +: 8] = acc[i];
        end
        w.k = PR'((1 << acc.size()) - 1);
        w.l = last;
        return w;
    endfunction

    // FIFO model: a read accepted at an edge presents its data just after it.
    initial begin
        logic rd_s;
        logic fl_s;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd_en;
            fl_s = flush;
            if (rd_s) begin
                check("rd_when_empty", 64'(fifo_empty), 64'd0);
            end
            @(posedge clk);
            #1;
            if (rd_s && fq.size() > 0) begin
                fifo_data = fq.pop_front();
                if (model_on) acc.push_back(fifo_data);
            end
            fifo_empty = stall || (fq.size() == 0);
            if (model_on) begin
                if (acc.size() == PR) begin
                    expq.push_back(pack_word(1'b0));
                    acc.delete();
                end
                if (fl_s && acc.size() > 0) begin
                    expq.push_back(pack_word(1'b1));
                    acc.delete();
                end
            end
        end
    end

    // Output monitor for the randomized phase.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (hold_pend) begin
                    check("hold", 64'({out_valid, out_data, out_keep, out_last}), 64'({1'b1, held}));
                    hold_pend = 1'b0;
                end
                if (out_valid) begin
                    if (out_ready) begin
                        if (expq.size() == 0) begin
                            check("unexpected_word", 64'({out_data, out_keep, out_last}), 64'd0);
                        end else begin
                            e = expq.pop_front();
                            check("rand_word", 64'({out_data, out_keep, out_last}), 64'(e));
                        end
                    end else begin
                        held = {out_data, out_keep, out_last};
                        hold_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   rd_cnt;
        int   first_rd;
        int   last_rd;
        int   v_cnt;
        int   v_idx;
        logic [OW-1:0] v_data;

        clk = 1'b0; reset = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
        flush = 1'b0; out_ready = 1'b0; stall = 1'b0; model_on = 1'b0; hold_pend = 1'b0;
        checks = 0; errors = 0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_state", 64'({out_valid, out_data, out_keep, out_last, fifo_rd_en}), 64'd0);
        step();

        // Directed vectors: bytes, optional flush, expected first word
        vecs[0] = '{4, 32'h44332211, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
        vecs[1] = '{3, 32'h00C3B2A1, 1'b1, 1'b1, 32'h00C3B2A1, 4'h7, 1'b1};
        vecs[2] = '{0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0};
        vecs[3] = '{1, 32'h0000005A, 1'b1, 1'b1, 32'h0000005A, 4'h1, 1'b1};
        vecs[4] = '{2, 32'h00003C7E, 1'b1, 1'b1, 32'h00003C7E, 4'h3, 1'b1};
        vecs[5] = '{4, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0};
        for (int k = 0; k < 6; k++) begin
            do_reset();
            out_ready = 1'b0;
            for (int i = 0; i < vecs[k].n; i++) push(vecs[k].bytes[i*8 +: 8]);
            repeat (8) step();
            if (vecs[k].fl) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
            repeat (3) step();
            @(negedge clk);
            check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vecs[k].exp_valid));
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d_word", k), 64'({out_data, out_keep, out_last}),
                      64'({vecs[k].exp_data, vecs[k].exp_keep, vecs[k].exp_last}));
            end
            out_ready = 1'b1;
            @(negedge clk);
            v_cnt = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) v_cnt++;
            end
            check($sformatf("vec%0d_no_extra", k), 64'(v_cnt), 64'd0);
            step();
        end

        // Full word latency and back-to-back reads
        do_reset();
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rd_cnt = 0; first_rd = -1; last_rd = -1; v_cnt = 0; v_idx = -1; v_data = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (out_valid) begin
                v_cnt++;
                v_idx = i;
                v_data = out_data;
            end
        end
        check("t1_rd_count", 64'(rd_cnt), 64'd4);
        check("t1_rd_span", 64'(last_rd - first_rd), 64'd3);
        check("t1_valid_once", 64'(v_cnt), 64'd1);
        check("t1_latency", 64'(v_idx - last_rd), 64'd2);
        check("t1_data", 64'(v_data), 64'h44332211);
        step();

        // Backpressure holds the word and stops reads
        do_reset();
        out_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_valid("t2_valid", 20);
        check("t2_word", 64'({out_data, out_keep, out_last}), 64'({32'h44332211, 4'hF, 1'b0}));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold", 64'({out_valid, out_data, fifo_rd_en}), 64'({1'b1, 32'h44332211, 1'b0}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_released", 64'(out_valid), 64'd0);
        wait_valid("t2_valid2", 20);
        check("t2_word2", 64'({out_data, out_keep, out_last}), 64'({32'h88776655, 4'hF, 1'b0}));
        step();

        // Empty stall between bytes
        do_reset();
        out_ready = 1'b1;
        push(8'hAA); push(8'hBB);
        repeat (4) step();
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
        end
        check("t3_no_rd_empty", 64'(rd_cnt), 64'd0);
        step();
        push(8'hCC); push(8'hDD);
        wait_valid("t3_valid", 20);
        check("t3_word", 64'({out_data, out_keep, out_last}), 64'({32'hDDCCBBAA, 4'hF, 1'b0}));
        step();

        // Flush while a read is in flight, then next word restarts at lane 0
        do_reset();
        out_ready = 1'b0;
        push(8'h01);
        repeat (3) step();
        push(8'h02);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_valid("t5_valid", 10);
        check("t5_word", 64'({out_data, out_keep, out_last}), 64'({32'h00000201, 4'h3, 1'b1}));
        out_ready = 1'b1;
        step();
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        wait_valid("t5_valid2", 20);
        check("t5_word2", 64'({out_data, out_keep, out_last}), 64'({32'h40302010, 4'hF, 1'b0}));
        step();

        // Reset mid-word drops the in-flight byte
        do_reset();
        out_ready = 1'b1;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        push(8'hF0); push(8'hF1); push(8'hF2); push(8'hF3);
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        check("t6_rd_in_reset", 64'(fifo_rd_en), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_outputs_zero", 64'({out_valid, out_data, out_keep, out_last}), 64'd0);
        wait_valid("t6_valid", 20);
        check("t6_word", 64'({out_data, out_keep, out_last}), 64'({32'hF2F1F0E4, 4'hF, 1'b0}));
        step();

        // Randomized traffic against the reference queues
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 60 && fq.size() < FIFO_DEPTH) push(8'($urandom));
            out_ready = ($urandom_range(0, 99) < 70);
            flush = ($urandom_range(0, 29) == 0);
            set_stall($urandom_range(0, 9) == 0);
            step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        set_stall(1'b0);
        repeat (40) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        check("rand_drained", 64'(expq.size() + acc.size() + fq.size()), 64'd0);
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
